// File: rtl/instr_encoder.sv
// instr_encoder: turns a mnemonic index plus operand fields into a 32-bit
// MIPS instruction word and queues it in a small output FIFO.
// Illegal mnemonics are accepted but dropped, and they raise a sticky err
// flag. inst_count counts the words that leave the FIFO.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] inst_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Instruction layouts. FMT_SYS is SYSCALL, which always emits 0x0000000C.
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_J    = 3'd2,
    FMT_COP0 = 3'd3,
    FMT_SYS  = 3'd4,
    FMT_BAD  = 3'd5
  } fmt_e;

  // Decoded view of one mnemonic. A keep_* bit passes that operand field
  // through; when it is clear the field is forced to zero.
  typedef struct packed {
    fmt_e       fmt;
    logic [5:0] op;
    logic [5:0] funct;
    logic       keep_rs;
    logic       keep_rt;
    logic       keep_rd;
    logic       keep_shamt;
    logic [4:0] cop_rs;
  } dec_t;

  dec_t        dec;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic [4:0]  rs_f, rt_f, rd_f, shamt_f;

  // Mnemonic decode table.
  always_comb begin
    // NOTE: every field gets a default here so no path through the case infers a latch.
    dec            = '0;
    dec.fmt        = FMT_BAD;
    dec.keep_rs    = 1'b1;
    dec.keep_rt    = 1'b1;
    dec.keep_rd    = 1'b1;
    dec.keep_shamt = 1'b0;
    unique case (mnem)
      // Shift-immediate R-type: rs is unused and shamt is live.
      6'd0:  begin dec.fmt = FMT_R; dec.funct = 6'd0;  dec.keep_rs = 1'b0; dec.keep_shamt = 1'b1; end
      6'd1:  begin dec.fmt = FMT_R; dec.funct = 6'd2;  dec.keep_rs = 1'b0; dec.keep_shamt = 1'b1; end
      6'd2:  begin dec.fmt = FMT_R; dec.funct = 6'd3;  dec.keep_rs = 1'b0; dec.keep_shamt = 1'b1; end
      // Variable shifts.
      6'd3:  begin dec.fmt = FMT_R; dec.funct = 6'd4;  end
      6'd4:  begin dec.fmt = FMT_R; dec.funct = 6'd6;  end
      6'd5:  begin dec.fmt = FMT_R; dec.funct = 6'd7;  end
      // JR uses rs only.
      6'd6:  begin dec.fmt = FMT_R; dec.funct = 6'd8;  dec.keep_rt = 1'b0; dec.keep_rd = 1'b0; end
      6'd7:  begin dec.fmt = FMT_SYS; end
      // MFHI/MFLO use rd only.
      6'd8:  begin dec.fmt = FMT_R; dec.funct = 6'd16; dec.keep_rs = 1'b0; dec.keep_rt = 1'b0; end
      6'd9:  begin dec.fmt = FMT_R; dec.funct = 6'd18; dec.keep_rs = 1'b0; dec.keep_rt = 1'b0; end
      // MULTU/DIVU write HI/LO, so rd is unused.
      6'd10: begin dec.fmt = FMT_R; dec.funct = 6'd25; dec.keep_rd = 1'b0; end
      6'd11: begin dec.fmt = FMT_R; dec.funct = 6'd27; dec.keep_rd = 1'b0; end
      // Three-register ALU ops.
      6'd12: begin dec.fmt = FMT_R; dec.funct = 6'd32; end
      6'd13: begin dec.fmt = FMT_R; dec.funct = 6'd33; end
      6'd14: begin dec.fmt = FMT_R; dec.funct = 6'd34; end
      6'd15: begin dec.fmt = FMT_R; dec.funct = 6'd35; end
      6'd16: begin dec.fmt = FMT_R; dec.funct = 6'd36; end
      6'd17: begin dec.fmt = FMT_R; dec.funct = 6'd37; end
      6'd18: begin dec.fmt = FMT_R; dec.funct = 6'd38; end
      6'd19: begin dec.fmt = FMT_R; dec.funct = 6'd39; end
      6'd20: begin dec.fmt = FMT_R; dec.funct = 6'd42; end
      6'd21: begin dec.fmt = FMT_R; dec.funct = 6'd43; end
      // Jumps.
      6'd22: begin dec.fmt = FMT_J; dec.op = 6'd2; end
      6'd23: begin dec.fmt = FMT_J; dec.op = 6'd3; end
      // Branches. BLEZ/BGTZ compare rs against zero, so rt is unused.
      6'd24: begin dec.fmt = FMT_I; dec.op = 6'd4; end
      6'd25: begin dec.fmt = FMT_I; dec.op = 6'd5; end
      6'd26: begin dec.fmt = FMT_I; dec.op = 6'd6; dec.keep_rt = 1'b0; end
      6'd27: begin dec.fmt = FMT_I; dec.op = 6'd7; dec.keep_rt = 1'b0; end
      // Immediate ALU ops. LUI has no rs source.
      6'd28: begin dec.fmt = FMT_I; dec.op = 6'd8;  end
      6'd29: begin dec.fmt = FMT_I; dec.op = 6'd9;  end
      6'd30: begin dec.fmt = FMT_I; dec.op = 6'd10; end
      6'd31: begin dec.fmt = FMT_I; dec.op = 6'd11; end
      6'd32: begin dec.fmt = FMT_I; dec.op = 6'd12; end
      6'd33: begin dec.fmt = FMT_I; dec.op = 6'd13; end
      6'd34: begin dec.fmt = FMT_I; dec.op = 6'd14; end
      6'd35: begin dec.fmt = FMT_I; dec.op = 6'd15; dec.keep_rs = 1'b0; end
      // Loads and stores.
      6'd36: begin dec.fmt = FMT_I; dec.op = 6'd32; end
      6'd37: begin dec.fmt = FMT_I; dec.op = 6'd33; end
      6'd38: begin dec.fmt = FMT_I; dec.op = 6'd35; end
      6'd39: begin dec.fmt = FMT_I; dec.op = 6'd36; end
      6'd40: begin dec.fmt = FMT_I; dec.op = 6'd37; end
      6'd41: begin dec.fmt = FMT_I; dec.op = 6'd40; end
      6'd42: begin dec.fmt = FMT_I; dec.op = 6'd41; end
      6'd43: begin dec.fmt = FMT_I; dec.op = 6'd43; end
      // Coprocessor-0 moves. The rs slot carries the sub-opcode.
      6'd44: begin dec.fmt = FMT_COP0; dec.op = 6'd16; dec.cop_rs = 5'd0; end
      6'd45: begin dec.fmt = FMT_COP0; dec.op = 6'd16; dec.cop_rs = 5'd4; end
      default: begin dec.fmt = FMT_BAD; end
    endcase
  end

  // Field masking followed by word assembly for the decoded layout.
  always_comb begin
    rs_f      = dec.keep_rs    ? rs    : 5'd0;
    rt_f      = dec.keep_rt    ? rt    : 5'd0;
    rd_f      = dec.keep_rd    ? rd    : 5'd0;
    shamt_f   = dec.keep_shamt ? shamt : 5'd0;
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    unique case (dec.fmt)
      FMT_R:    enc_word = {6'd0, rs_f, rt_f, rd_f, shamt_f, dec.funct};
      FMT_I:    enc_word = {dec.op, rs_f, rt_f, imm16};
      FMT_J:    enc_word = {dec.op, target26};
      FMT_COP0: enc_word = {dec.op, dec.cop_rs, rt, rd, 11'd0};
      FMT_SYS:  enc_word = 32'h0000_000C;
      default:  enc_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FIFO. The pointers carry one extra wrap bit so that full and empty
  // can be told apart.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty;
  logic        req_fire, push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Readiness depends only on full, never on a same-cycle pop, so there is no
  // combinational path from inst_ready to req_ready.
  assign req_ready  = !fifo_full && !rst;
  assign req_fire   = req_valid && req_ready;
  assign push       = req_fire && enc_legal;
  assign inst_valid = !fifo_empty;
  assign pop        = inst_valid && inst_ready;
  // The word bus reads as zero whenever the queue holds nothing.
  assign inst_data  = fifo_empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

  // Storage array is written on push only.
  // NOTE: the array has no reset. The empty flag (set by reset) masks any stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= enc_word;
  end

  // Read and write pointers advance on pop and push.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky illegal-mnemonic flag. A new illegal request wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err <= 1'b0;
    else if (req_fire && !enc_legal) err <= 1'b1;
    else if (err_clr)              err <= 1'b0;
  end

  // Delivered-word counter. It wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      inst_count <= 16'd0;
    else if (pop) inst_count <= inst_count + 16'd1;
  end

endmodule
